// File: rtl/hcsr04_echo_emulator_pkg.sv
// Shared definitions for the HC-SR04 echo emulator and the ranging controller
// that talks to it: FSM state encoding, 12 MHz timing constants and a
// distance clamp helper.
package hcsr04_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIG_HIGH,
      BURST,
      ECHO,
      HOLDOFF
   } echo_state_t;

   // 58 us per centimetre and the 10 us trigger width, both at 12 MHz
   localparam int unsigned CYCLES_PER_CM_12M = 696;
   localparam int unsigned TRIG_CYCLES_12M   = 120;

   // Width of the no-object counter; holds 38 ms at 12 MHz plus jitter
   localparam int unsigned NO_OBJ_CNT_W = 19;

   // Clamp a programmed distance into the sensor's usable range
   function automatic logic [15:0] clamp_cm(input logic [15:0] cm,
                                           input logic [15:0] lo,
                                           input logic [15:0] hi);
      if (cm < lo) begin
         return lo;
      end else if (cm > hi) begin
         return hi;
      end else begin
         return cm;
      end
   endfunction

endpackage

// File: rtl/hcsr04_echo_emulator_if.sv
// Pin-level HC-SR04 interface. The master side is the ranging controller
// (or a bench playing its part), the slave side is the emulated sensor.
interface hcsr04_echo_emulator_if;

   logic        trig_in;
   logic [15:0] distance_cm;
   logic        dist_valid;
   logic        echo;
   logic        busy;
   logic        meas_done;
   logic        err_short_trig;

   modport master (
      output trig_in,
      output distance_cm,
      output dist_valid,
      input  echo,
      input  busy,
      input  meas_done,
      input  err_short_trig
   );

   modport slave (
      input  trig_in,
      input  distance_cm,
      input  dist_valid,
      output echo,
      output busy,
      output meas_done,
      output err_short_trig
   );

endinterface

// File: rtl/hcsr04_echo_emulator_sync.sv
// Two-flop synchronizer for the asynchronous trig pin, followed by a third
// register that provides the clean level and one-cycle rise/fall pulses.
// The rise pulse is asserted in the first cycle the level reads high, and the
// fall pulse in the first cycle it reads low.
module trig_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic sync0;
   logic sync1;

   // Metastability chain, then edge detection against the previous level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync0 <= 1'b0;
         sync1 <= 1'b0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync0 <= async_in;
         sync1 <= sync0;
         level <= sync1;
         rise  <= sync1 & ~level;
         fall  <= ~sync1 & level;
      end
   end

endmodule

// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 target emulator: validates the trig pulse width, waits the burst
// delay, then drives an echo pulse of distance * CYCLES_PER_CM clocks (or the
// no-object width), followed by a hold-off period.
// Optional build macro ECHO_JITTER_EN appends pseudo-random sub-centimetre
// jitter (from a 16-bit LFSR) to each echo width.
module hcsr04_echo_emulator
   import hcsr04_pkg::*;
#(
   parameter int unsigned TRIG_MIN_CYCLES    = TRIG_CYCLES_12M,
   parameter int unsigned CYCLES_PER_CM      = CYCLES_PER_CM_12M,
   parameter int unsigned BURST_DELAY_CYCLES = 2400,
   parameter int unsigned MIN_CM             = 2,
   parameter int unsigned MAX_CM             = 400,
   parameter int unsigned NO_OBJ_CYCLES      = 456000,
   parameter int unsigned HOLDOFF_CYCLES     = 1200
`ifdef ECHO_JITTER_EN
   ,
   parameter logic [7:0]  JITTER_MASK        = 8'h3F
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   hcsr04_echo_emulator_if.slave bus
);

   // One counter is shared by the trig-width, burst and hold-off phases
   localparam int unsigned PH_MAX0 = (BURST_DELAY_CYCLES > HOLDOFF_CYCLES) ?
                                     BURST_DELAY_CYCLES : HOLDOFF_CYCLES;
   localparam int unsigned PH_MAX  = (PH_MAX0 > TRIG_MIN_CYCLES) ? PH_MAX0 : TRIG_MIN_CYCLES;
   localparam int unsigned PH_W    = $clog2(PH_MAX + 1);

`ifdef ECHO_JITTER_EN
   // The inner counter also times the jitter tail, so it must reach 255
   localparam int unsigned INNER_MAX = (CYCLES_PER_CM > 256) ? CYCLES_PER_CM : 256;
`else
   localparam int unsigned INNER_MAX = CYCLES_PER_CM;
`endif
   localparam int unsigned INNER_W = (INNER_MAX > 1) ? $clog2(INNER_MAX) : 1;

   echo_state_t            state;
   logic [PH_W-1:0]        phase_cnt;
   logic [INNER_W-1:0]     inner_cnt;
   logic [15:0]            cm_cnt;
   logic [NO_OBJ_CNT_W-1:0] no_obj_cnt;
   logic [NO_OBJ_CNT_W-1:0] no_obj_last;
   logic [15:0]            n_cm;
   logic                   valid_q;
   logic                   echo_q;
   logic                   meas_done_q;
   logic                   err_q;

   logic                   trig_level;
   logic                   trig_rise;
   logic                   trig_fall;

   logic                   inner_last;
   logic                   cm_last;
   logic                   echo_last;

`ifdef ECHO_JITTER_EN
   logic [15:0]            lfsr;
   logic [7:0]             jit_q;
   logic                   in_tail;
   logic                   lfsr_fb;

   assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign no_obj_last = NO_OBJ_CNT_W'(NO_OBJ_CYCLES - 1) + {{(NO_OBJ_CNT_W-8){1'b0}}, jit_q};
`else
   assign no_obj_last = NO_OBJ_CNT_W'(NO_OBJ_CYCLES - 1);
`endif

   trig_sync_edge u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (bus.trig_in),
      .level    (trig_level),
      .rise     (trig_rise),
      .fall     (trig_fall)
   );

   // Decide whether the current cycle is the last echo-high clock
   always_comb begin
      inner_last = (inner_cnt == INNER_W'(CYCLES_PER_CM - 1));
      cm_last    = (cm_cnt == n_cm - 16'd1);
      echo_last  = 1'b0;
      if (!valid_q) begin
         echo_last = (no_obj_cnt == no_obj_last);
`ifdef ECHO_JITTER_EN
      end else if (in_tail) begin
         echo_last = (inner_cnt == INNER_W'(jit_q - 8'd1));
      end else begin
         echo_last = inner_last && cm_last && (jit_q == 8'd0);
`else
      end else begin
         echo_last = inner_last && cm_last;
`endif
      end
   end

   // Measurement sequencer: trig check, burst delay, echo, hold-off
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         phase_cnt   <= '0;
         inner_cnt   <= '0;
         cm_cnt      <= '0;
         no_obj_cnt  <= '0;
         n_cm        <= '0;
         valid_q     <= 1'b0;
         echo_q      <= 1'b0;
         meas_done_q <= 1'b0;
         err_q       <= 1'b0;
`ifdef ECHO_JITTER_EN
         lfsr        <= 16'hACE1;
         jit_q       <= '0;
         in_tail     <= 1'b0;
`endif
      end else begin
         meas_done_q <= 1'b0;
         err_q       <= 1'b0;
         case (state)
            IDLE: begin
               if (trig_rise) begin
                  state     <= TRIG_HIGH;
                  phase_cnt <= PH_W'(1);
               end
            end

            TRIG_HIGH: begin
               if (trig_fall) begin
                  phase_cnt <= '0;
                  if (phase_cnt >= PH_W'(TRIG_MIN_CYCLES)) begin
                     n_cm    <= clamp_cm(bus.distance_cm, 16'(MIN_CM), 16'(MAX_CM));
                     valid_q <= bus.dist_valid;
                     state   <= BURST;
`ifdef ECHO_JITTER_EN
                     jit_q   <= lfsr[7:0] & JITTER_MASK;
                     lfsr    <= {lfsr[14:0], lfsr_fb};
`endif
                  end else begin
                     err_q <= 1'b1;
                     state <= IDLE;
                  end
               end else if (trig_level && (phase_cnt < PH_W'(TRIG_MIN_CYCLES))) begin
                  phase_cnt <= phase_cnt + 1'b1;
               end
            end

            BURST: begin
               if (phase_cnt == PH_W'(BURST_DELAY_CYCLES - 1)) begin
                  echo_q     <= 1'b1;
                  state      <= ECHO;
                  phase_cnt  <= '0;
                  inner_cnt  <= '0;
                  cm_cnt     <= '0;
                  no_obj_cnt <= '0;
`ifdef ECHO_JITTER_EN
                  in_tail    <= 1'b0;
`endif
               end else begin
                  phase_cnt <= phase_cnt + 1'b1;
               end
            end

            ECHO: begin
               if (echo_last) begin
                  echo_q      <= 1'b0;
                  meas_done_q <= 1'b1;
                  state       <= HOLDOFF;
                  phase_cnt   <= '0;
               end else if (!valid_q) begin
                  no_obj_cnt <= no_obj_cnt + 1'b1;
`ifdef ECHO_JITTER_EN
               end else if (in_tail) begin
                  inner_cnt <= inner_cnt + 1'b1;
               end else if (inner_last) begin
                  inner_cnt <= '0;
                  if (cm_last) begin
                     in_tail <= 1'b1;
                  end else begin
                     cm_cnt <= cm_cnt + 16'd1;
                  end
`else
               end else if (inner_last) begin
                  inner_cnt <= '0;
                  cm_cnt    <= cm_cnt + 16'd1;
`endif
               end else begin
                  inner_cnt <= inner_cnt + 1'b1;
               end
            end

            HOLDOFF: begin
               if (phase_cnt == PH_W'(HOLDOFF_CYCLES - 1)) begin
                  state     <= IDLE;
                  phase_cnt <= '0;
               end else begin
                  phase_cnt <= phase_cnt + 1'b1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.echo           = echo_q;
   assign bus.busy           = (state != IDLE);
   assign bus.meas_done      = meas_done_q;
   assign bus.err_short_trig = err_q;

endmodule

// File: doc/hcsr04_echo_emulator.md
Name: hcsr04_echo_emulator

Overview:
Emulates the target end of the HC-SR04 trigger/echo protocol for hardware-in-loop testing of the ultrasonic ranging controller.
- Accepts a trig pulse and checks its width.
- Waits the sensor's burst delay, then drives an echo pulse whose width encodes a programmed distance.
- Sits on the FPGA pins or bench fabric opposite the ranging controller.
- Clock is 12 MHz nominal: 10 us = 120 cycles, 58 us/cm = 696 cycles.

Parameters:
- TRIG_MIN_CYCLES, 120, minimum synchronized trig-high width accepted as valid.
- CYCLES_PER_CM, 696, echo-high clocks per centimetre.
- BURST_DELAY_CYCLES, 2400, clocks from accepted trig fall to echo rise (200 us burst).
- MIN_CM, 2, lower clamp on distance.
- MAX_CM, 400, upper clamp on distance.
- NO_OBJ_CYCLES, 456000, echo width when no object is present (38 ms).
- HOLDOFF_CYCLES, 1200, dead time after echo fall before the next trig is accepted.
- JITTER_MASK, 8'h3F, jitter mask; used only with ECHO_JITTER_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- trig_in  in  1  trigger from controller; asynchronous.
- distance_cm  in  16  programmed target distance.
- dist_valid  in  1  1 = object present; 0 = no-echo/timeout emulation.
- echo  out  1  echo pulse to controller; registered.
- busy  out  1  high in any state other than IDLE.
- meas_done  out  1  one-cycle pulse in the cycle echo falls.
- err_short_trig  out  1  one-cycle pulse when trig is rejected as too short.

Behaviour:
- Reset values: echo=0, busy=0, meas_done=0, err_short_trig=0, state=IDLE, all counters 0, sync flops 0.
- Reset mid-operation: echo drops on the asserting edge, no meas_done, state returns to IDLE.
- trig_in passes a 2-flop synchronizer to give trig_s; rise/fall are detected on trig_s.
- IDLE: on trig_s rise, go to TRIG_HIGH with width counter = 1.
- TRIG_HIGH: while trig_s=1, increment the width counter, saturating at TRIG_MIN_CYCLES.
  - On trig_s fall with count >= TRIG_MIN_CYCLES: latch the effective distance N and dist_valid, then go to BURST with counter 0.
  - On fall with count < TRIG_MIN_CYCLES: pulse err_short_trig and return to IDLE.
  - Trig held high indefinitely: stays in TRIG_HIGH.
- N = clamp(distance_cm, MIN_CM, MAX_CM), sampled only at the accepting fall. Later changes to distance_cm are ignored until the next measurement.
- BURST: echo rises exactly BURST_DELAY_CYCLES clocks after the fall-detect cycle; then go to ECHO.
- ECHO: echo held high for exactly N*CYCLES_PER_CM clocks, or NO_OBJ_CYCLES if the latched dist_valid=0.
  - No multiplier: inner counter 0..CYCLES_PER_CM-1, outer cm counter 0..N-1.
  - The no-object case uses a single 19-bit counter.
  - Echo falls and meas_done pulses in the same cycle; then go to HOLDOFF.
- HOLDOFF: count HOLDOFF_CYCLES, then go to IDLE.
- Edges on trig_s in BURST, ECHO or HOLDOFF are ignored; there is no queuing.
- A trig already high when entering IDLE is not accepted; a fresh rise is required.
- busy = (state != IDLE).
- Paired with the ranging controller, N cm must read back as exactly N.

Optional Feature:
- Macro: ECHO_JITTER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per accepted trig.
  - (lfsr[7:0] & JITTER_MASK) extra clocks are appended to echo width, in both object and no-object cases.
  - Jitter is < CYCLES_PER_CM, so the controller's integer reading is unchanged.
- Undefined: no LFSR logic; widths are exact.

Decomposition:
- Package hcsr04_pkg holds:
  - the state enum IDLE/TRIG_HIGH/BURST/ECHO/HOLDOFF;
  - shared constants CYCLES_PER_CM_12M=696 and TRIG_CYCLES_12M=120, reused by the ranging controller.
- One sub-module, trig_sync_edge: 2-flop synchronizer with registered rise/fall pulses and level output.

Test Plan:
1. Trig high 121 clocks, distance_cm=10, dist_valid=1 -> echo rises 2400 clocks after fall detect, high 6960 clocks; meas_done once; busy low 1200 clocks after echo fall. Paired controller reads 10.
2. Trig high 50 clocks -> err_short_trig one pulse, echo stays 0, busy returns 0.
3. distance_cm=1000 -> echo width 278400 (clamped to 400). distance_cm=0 -> width 1392 (clamped to 2).
4. dist_valid=0 -> echo width 456000. Changing distance_cm to 50 during ECHO -> width unchanged.
5. Second valid trig during ECHO and during HOLDOFF -> ignored, a single echo only. Then rst pulsed mid-ECHO -> echo=0 next edge, no meas_done, next trig accepted normally.
6. With ECHO_JITTER_EN, 20 back-to-back measurements at 25 cm -> widths in [17400, 17463], not all equal; paired controller reads 25 every time.
